// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, opcode width and requester IDs.
// Both the alu datapath and the alu_arbiter front end use these codes.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_REG0 = 4'd0;
  localparam alu_op_t OP_REG1 = 4'd1;
  localparam alu_op_t OP_ADD  = 4'd2;
  localparam alu_op_t OP_SUB  = 4'd3;
  localparam alu_op_t OP_AND  = 4'd4;
  localparam alu_op_t OP_OR   = 4'd5;
  localparam alu_op_t OP_XOR  = 4'd6;
  localparam alu_op_t OP_NOT  = 4'd7;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. ADD/SUB wrap at the word width, NOT inverts
// operand b, and opcodes outside 0-7 produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic [ALU_OP_W-1:0]  i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_REG0: o_result = i_a;
      OP_REG1: o_result = i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOT:  o_result = ~i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one alu between two valid/ready requesters,
// with a one-entry output register that tags each result with its requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ALU_OP_W-1:0]  req0_op,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ALU_OP_W-1:0]  req1_op,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_zero
);

  logic                 r_respValid;
  logic                 r_respId;
  logic                 r_respZero;
  logic [WORD_SIZE-1:0] r_respData;
  logic                 r_lastGrant;

  logic                 w_slotFree;
  logic                 w_grantValid;
  logic                 w_grantId;
  logic                 w_accept;
  logic [ALU_OP_W-1:0]  w_aluOp;
  logic [WORD_SIZE-1:0] w_aluA;
  logic [WORD_SIZE-1:0] w_aluB;
  logic [WORD_SIZE-1:0] w_aluResult;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    w_grantValid = req0_valid || req1_valid;
    w_grantId    = REQ_CORE;
    if (req0_valid && req1_valid) begin
      w_grantId = ~r_lastGrant;
    end else if (req1_valid) begin
      w_grantId = REQ_AUX;
    end
  end

  // A draining result frees the slot in the same cycle, allowing back-to-back accepts.
  assign w_slotFree = !r_respValid || resp_ready;
  assign w_accept   = !reset && w_slotFree && w_grantValid;
  assign req0_ready = w_accept && (w_grantId == REQ_CORE);
  assign req1_ready = w_accept && (w_grantId == REQ_AUX);

  assign w_aluOp = (w_grantId == REQ_AUX) ? req1_op : req0_op;
  assign w_aluA  = (w_grantId == REQ_AUX) ? req1_a  : req0_a;
  assign w_aluB  = (w_grantId == REQ_AUX) ? req1_b  : req0_b;

  alu #(
    .WORD_SIZE(WORD_SIZE)
  ) u_alu (
    .i_op    (w_aluOp),
    .i_a     (w_aluA),
    .i_b     (w_aluB),
    .o_result(w_aluResult)
  );

  // lastGrant resets to AUX so the core wins the first conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respZero  <= 1'b1;
      r_respId    <= REQ_CORE;
      r_lastGrant <= REQ_AUX;
    end else if (w_accept) begin
      r_respValid <= 1'b1;
      r_respData  <= w_aluResult;
      r_respZero  <= (w_aluResult == '0);
      r_respId    <= w_grantId;
      r_lastGrant <= w_grantId;
    end else if (r_respValid && resp_ready) begin
      r_respValid <= 1'b0;
    end
  end

  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;
  assign resp_zero  = r_respZero;
  assign resp_id    = r_respId;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model is compared on
// every cycle, and hand-computed literal expectations pin selected cycles.
module tb_alu_arbiter;

  localparam int WS = 18;
  localparam logic [WS-1:0] MASK = {WS{1'b1}};

  logic          clock;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_op, req1_op;
  logic [WS-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          resp_valid, resp_ready, resp_id, resp_zero;
  logic [WS-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WORD_SIZE(WS)) dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_zero (resp_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic logic [WS-1:0] modelAlu(input logic [3:0] op, input logic [WS-1:0] a,
                                             input logic [WS-1:0] b);
    longint unsigned r;
    case (op)
      4'd0: r = a;
      4'd1: r = b;
      4'd2: r = (longint'(a) + longint'(b)) % (longint'(1) << WS);
      4'd3: r = (longint'(a) + (longint'(1) << WS) - longint'(b)) % (longint'(1) << WS);
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = (~b) & MASK;
      default: r = 0;
    endcase
    return r[WS-1:0];
  endfunction

  // Model of the output register and round-robin history.
  logic          started = 1'b0;
  logic          mValid, mId, mZero, mLast;
  logic [WS-1:0] mData;

  function automatic int modelWinner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return (last == 1'b1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clock) begin
    int w;
    if (reset) begin
      started = 1'b1;
      mValid  = 1'b0;
      mData   = '0;
      mZero   = 1'b1;
      mId     = 1'b0;
      mLast   = 1'b1;
    end else if (started) begin
      w = modelWinner(req0_valid, req1_valid, mLast);
      if ((!mValid || resp_ready) && w >= 0) begin
        mData  = (w == 0) ? modelAlu(req0_op, req0_a, req0_b) : modelAlu(req1_op, req1_a, req1_b);
        mZero  = (mData == 0);
        mId    = (w == 1);
        mLast  = (w == 1);
        mValid = 1'b1;
      end else if (mValid && resp_ready) begin
        mValid = 1'b0;
      end
    end
  end

  logic          litArm = 1'b0;
  logic          litValid, litId, litZero, litRdy0, litRdy1;
  logic [WS-1:0] litData;
  int            cycle = 0;

  task automatic checkOutput(input string name, input logic [WS-1:0] actual,
                             input logic [WS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, actual, expected);
    end
  endtask

  // Single compare process: model every cycle, literals when armed.
  always @(negedge clock) begin
    int w;
    logic eR0, eR1;
    if (started) begin
      w   = modelWinner(req0_valid, req1_valid, mLast);
      eR0 = !reset && (!mValid || resp_ready) && (w == 0);
      eR1 = !reset && (!mValid || resp_ready) && (w == 1);
      checkOutput("model_resp_valid", WS'(resp_valid), WS'(mValid));
      checkOutput("model_req0_ready", WS'(req0_ready), WS'(eR0));
      checkOutput("model_req1_ready", WS'(req1_ready), WS'(eR1));
      checkOutput("model_resp_zero", WS'(resp_zero), WS'(mZero));
      checkOutput("model_resp_data", resp_data, mData);
      checkOutput("model_resp_id", WS'(resp_id), WS'(mId));
    end
    if (litArm) begin
      checkOutput("lit_resp_valid", WS'(resp_valid), WS'(litValid));
      checkOutput("lit_resp_id", WS'(resp_id), WS'(litId));
      checkOutput("lit_resp_data", resp_data, litData);
      checkOutput("lit_resp_zero", WS'(resp_zero), WS'(litZero));
      checkOutput("lit_req0_ready", WS'(req0_ready), WS'(litRdy0));
      checkOutput("lit_req1_ready", WS'(req1_ready), WS'(litRdy1));
    end
    cycle++;
  end

  task automatic applyStimulus(input logic rst, input logic v0, input logic [3:0] op0,
                               input logic [WS-1:0] a0, input logic [WS-1:0] b0,
                               input logic v1, input logic [3:0] op1,
                               input logic [WS-1:0] a1, input logic [WS-1:0] b1,
                               input logic rr);
    @(posedge clock);
    #1;
    reset      = rst;
    req0_valid = v0;
    req0_op    = op0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_op    = op1;
    req1_a     = a1;
    req1_b     = b1;
    resp_ready = rr;
  endtask

  task automatic expectResp(input logic v, input logic id, input logic [WS-1:0] data,
                            input logic z, input logic r0, input logic r1);
    litValid = v;
    litId    = id;
    litData  = data;
    litZero  = z;
    litRdy0  = r0;
    litRdy1  = r1;
    litArm   = 1'b1;
    @(negedge clock);
    #1;
    litArm = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 18'd1;       req0_b = 18'd1;
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 18'h3FFFF;   req1_b = 18'h00FFF;
    resp_ready = 1'b1;

    // Reset held two edges with both requesters valid.
    @(posedge clock);
    expectResp(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0);

    // Continuous contention: first conflict to req0, then alternate.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd2, 18'd1, 18'd1, 1'b1, 4'd6, 18'h3FFFF, 18'h00FFF, 1'b1);
      if (i == 0)          expectResp(1'b0, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0);
      else if (i % 2 == 1) expectResp(1'b1, 1'b0, 18'h00002, 1'b0, 1'b0, 1'b1);
      else                 expectResp(1'b1, 1'b1, 18'h3F000, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b1, 18'h3F000, 1'b0, 1'b0, 1'b0);

    // Single requester: wrapping ADD then SUB to zero.
    applyStimulus(1'b0, 1'b1, 4'd2, 18'h3FFFF, 18'd2, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b0, 1'b1, 18'h3F000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd3, 18'd5, 18'd5, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b0, 18'h00001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0);

    // Backpressure: OR result held three cycles while req1 waits.
    applyStimulus(1'b0, 1'b1, 4'd5, 18'h12, 18'h21, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0);
    expectResp(1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1, 4'd4, 18'h0F0F, 18'h00FF, 1'b0);
      expectResp(1'b1, 1'b0, 18'h00033, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1, 4'd4, 18'h0F0F, 18'h00FF, 1'b1);
    expectResp(1'b1, 1'b0, 18'h00033, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b1, 18'h0000F, 1'b0, 1'b0, 1'b0);

    // Unused opcode 9 from req1, then NOT of zero from req0.
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1, 4'd9, 18'd5, 18'd6, 1'b1);
    expectResp(1'b0, 1'b1, 18'h0000F, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd7, 18'h01234, 18'h00000, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b1, 18'h00000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 1'b0);

    // Reset while a result is stalled; the next conflict returns to req0.
    applyStimulus(1'b0, 1'b1, 4'd2, 18'd3, 18'd4, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0);
    expectResp(1'b0, 1'b0, 18'h3FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0);
    expectResp(1'b1, 1'b0, 18'h00007, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd2, 18'd1, 18'd1, 1'b1, 4'd6, 18'h3FFFF, 18'h00FFF, 1'b0);
    expectResp(1'b1, 1'b0, 18'h00007, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd2, 18'd1, 18'd1, 1'b1, 4'd6, 18'h3FFFF, 18'h00FFF, 1'b0);
    expectResp(1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0);
    expectResp(1'b1, 1'b0, 18'h00002, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b1, 1'b0, 18'h00002, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b0, 4'd0, 18'h0, 18'h0, 1'b1);
    expectResp(1'b0, 1'b0, 18'h00002, 1'b0, 1'b0, 1'b0);

    @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
